mux_scan_seq: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_selcnt.sv | 47 ++++
 rtl/mux_scan_seq.sv | 150 +++++++++++++++
 tb/tb_mux_scan_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the 8:1 mux scan sequencer: default widths and FSM state codes.
// Used by mux_scan_seq and mux_scan_selcnt.
package mux_scan_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int NCH_DEF   = 1 << SEL_W_DEF;
  localparam int LAST_CNT  = NCH_DEF - 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mux_scan_selcnt.sv
// Select/progress counter for the mux scan: up/down modulo-2**SEL_W counter with
// load, enable and direction. Owns the mux select and the captured-channel count.
module mux_scan_selcnt
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] count
);

  logic [SEL_W-1:0] sel_d, sel_q;
  logic [SEL_W-1:0] count_d, count_q;

  // Load wins over stepping; modulo wrap comes free because NCH is exactly 2**SEL_W.
  always_comb begin
    sel_d   = sel_q;
    count_d = count_q;
    if (load) begin
      sel_d   = load_val;
      count_d = '0;
    end else if (en) begin
      sel_d   = dir ? (sel_q - 1'b1) : (sel_q + 1'b1);
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      count_q <= '0;
    end else begin
      sel_q   <= sel_d;
      count_q <= count_d;
    end
  end

  assign sel   = sel_q;
  assign count = count_q;

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer upstream of the 8:1 mux: walks sel over all channels, captures y_in
// per channel and publishes a registered snapshot with a start/busy/done handshake.
// Optional feature macro: MUX_SCAN_PARITY_EN adds exp_par, parity and par_err.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    descend,
  input  logic                    hold,
  input  logic                    y_in,
`ifdef MUX_SCAN_PARITY_EN
  input  logic                    exp_par,
  output logic                    parity,
  output logic                    par_err,
`endif
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<SEL_W)-1:0]   snap
);

  localparam int               NCH      = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

  state_t           state_d, state_q;
  logic             dir_d, dir_q;
  logic [NCH-1:0]   capture_d, capture_q;
  logic [NCH-1:0]   snap_d, snap_q;
  logic             done_d, done_q;
  logic             busy_d, busy_q;
  logic             cnt_load;
  logic [SEL_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             final_step;
  logic [SEL_W-1:0] count;

  mux_scan_selcnt #(.SEL_W(SEL_W)) u_selcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .dir      (dir_q),
    .sel      (sel),
    .count    (count)
  );

  // The final capture reloads sel to 0 so the descending wrap to NCH-1 never shows.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    capture_d    = capture_q;
    snap_d       = snap_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    final_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SCAN;
          dir_d        = descend;
          capture_d    = '0;
          cnt_load     = 1'b1;
          cnt_load_val = descend ? LAST_SEL : '0;
        end
      end
      ST_SCAN: begin
        if (!hold) begin
          cnt_en         = 1'b1;
          capture_d[sel] = y_in;
          if (count == LAST_SEL) begin
            final_step   = 1'b1;
            state_d      = ST_DONE;
            snap_d       = capture_d;
            done_d       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      capture_q <= '0;
      snap_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      capture_q <= capture_d;
      snap_q    <= snap_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign snap = snap_q;

`ifdef MUX_SCAN_PARITY_EN
  logic exp_par_d, exp_par_q;
  logic parity_d, parity_q;
  logic par_err_d, par_err_q;

  // Expected parity is captured with start so the upstream driver can move on.
  always_comb begin
    exp_par_d = exp_par_q;
    parity_d  = parity_q;
    par_err_d = 1'b0;
    if (state_q == ST_IDLE && start) begin
      exp_par_d = exp_par;
    end
    if (final_step) begin
      parity_d  = ^capture_d;
      par_err_d = (^capture_d) != exp_par_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_par_q <= 1'b0;
      parity_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      exp_par_q <= exp_par_d;
      parity_q  <= parity_d;
      par_err_q <= par_err_d;
    end
  end

  assign parity  = parity_q;
  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: a behavioural mux feeds y_in and an
// abstract channel-order model predicts sel/busy/done/snap (and parity when enabled).
module tb_mux_scan_seq;
  import mux_scan_pkg::*;

  localparam int SEL_W = SEL_W_DEF;
  localparam int NCH   = NCH_DEF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             descend;
  logic             hold;
  logic             y_in;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [NCH-1:0]   snap;
  logic [NCH-1:0]   mux_d;
  logic [NCH-1:0]   last_snap;
`ifdef MUX_SCAN_PARITY_EN
  logic             exp_par;
  logic             parity;
  logic             par_err;
  logic             last_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y_in = mux_d[sel];

  mux_scan_seq #(.SEL_W(SEL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .descend (descend),
    .hold    (hold),
    .y_in    (y_in),
`ifdef MUX_SCAN_PARITY_EN
    .exp_par (exp_par),
    .parity  (parity),
    .par_err (par_err),
`endif
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .snap    (snap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One complete scan: k counts channels already captured, so the channel on sel is
  // k (ascending) or NCH-1-k (descending); a held cycle leaves k unchanged.
  task automatic applyStimulus(input logic [NCH-1:0] d, input logic desc,
                               input int hold_at, input int hold_len,
                               input bit rand_hold, input logic par_in,
                               input string tag);
    int   k = 0;
    int   cyc = 0;
    int   held = 0;
    int   exp_ch;
    logic h;
    mux_d   = d;
    descend = desc;
    start   = 1'b1;
    hold    = rand_hold ? 1'($urandom_range(0, 1)) : 1'((hold_at == 0) && (hold_len > 0));
`ifdef MUX_SCAN_PARITY_EN
    exp_par = par_in;
`endif
    tick();
`ifdef MUX_SCAN_PARITY_EN
    exp_par = ~par_in;
`endif
    while (k < NCH && cyc < 4 * NCH) begin
      exp_ch = desc ? (NCH - 1 - k) : k;
      checkOutput({tag, "_sel"}, 32'(sel), 32'(exp_ch));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
      checkOutput({tag, "_snap_stable"}, 32'(snap), 32'(last_snap));
      h = 1'b0;
      if (k == hold_at && held < hold_len) h = 1'b1;
      else if (rand_hold && held < 6 && $urandom_range(0, 3) == 0) h = 1'b1;
      if (h) held++;
      hold    = h;
      start   = 1'($urandom_range(0, 1));
      descend = 1'($urandom_range(0, 1));
      tick();
      if (!h) k++;
      cyc++;
    end
    checkOutput({tag, "_scan_len"}, 32'(k), 32'(NCH));
    hold = 1'b0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sel_done"}, 32'(sel), 32'd0);
    checkOutput({tag, "_snap"}, 32'(snap), 32'(d));
`ifdef MUX_SCAN_PARITY_EN
    checkOutput({tag, "_parity"}, 32'(parity), 32'(^d));
    checkOutput({tag, "_par_err"}, 32'(par_err), 32'((^d) != par_in));
    last_parity = ^d;
`endif
    last_snap = d;
    start = 1'b1;
    tick();
    checkOutput({tag, "_done_once"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sel_idle"}, 32'(sel), 32'd0);
    checkOutput({tag, "_snap_hold"}, 32'(snap), 32'(d));
`ifdef MUX_SCAN_PARITY_EN
    checkOutput({tag, "_par_err_once"}, 32'(par_err), 32'd0);
`endif
    start = 1'b0;
    tick();
    checkOutput({tag, "_no_requeue"}, 32'(busy), 32'd0);
    checkOutput({tag, "_no_done2"}, 32'(done), 32'd0);
    checkOutput({tag, "_snap_kept"}, 32'(snap), 32'(d));
  endtask

  task automatic resetMidScan(input logic [NCH-1:0] d);
    mux_d   = d;
    descend = 1'b0;
    hold    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("rst_mid_sel_before", 32'(sel), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_sel", 32'(sel), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_snap", 32'(snap), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("rst_mid_parity", 32'(parity), 32'd0);
    last_parity = 1'b0;
`endif
    last_snap = '0;
    repeat (3) begin
      tick();
      checkOutput("rst_mid_no_done", 32'(done), 32'd0);
      checkOutput("rst_mid_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    descend   = 1'b0;
    hold      = 1'b0;
    mux_d     = '0;
    last_snap = '0;
`ifdef MUX_SCAN_PARITY_EN
    exp_par     = 1'b0;
    last_parity = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_snap", 32'(snap), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("reset_parity", 32'(parity), 32'd0);
    checkOutput("reset_par_err", 32'(par_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    applyStimulus(8'hA5, 1'b0, -1, 0, 1'b0, 1'b0, "asc");
    applyStimulus(8'h3C, 1'b1, -1, 0, 1'b0, 1'b0, "desc");
    applyStimulus(8'hF0, 1'b0, 4, 3, 1'b0, 1'b0, "hold");
    applyStimulus(8'h5A, 1'b1, 0, 2, 1'b0, 1'b1, "start_hold");
    resetMidScan(8'hFF);
    applyStimulus(8'h81, 1'b0, -1, 0, 1'b0, 1'b0, "post_rst");
    applyStimulus(8'h07, 1'b0, -1, 0, 1'b0, 1'b0, "par_exp0");
    applyStimulus(8'h07, 1'b1, -1, 0, 1'b0, 1'b1, "par_exp1");

    for (int i = 0; i < 24; i++) begin
      applyStimulus(NCH'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
                    1'b1, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
